// File: rtl/sync_fifo_pkg.sv
// Shared helpers and types for the parametrised synchronous FIFO.
// The error-kind enum is what bound-in assertions use to classify sticky errors.
package sync_fifo_pkg;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OVF  = 2'd1,
    ERR_UDF  = 2'd2
  } fifo_err_e;

  // Occupancy needs one more bit than the address so that DEPTH itself fits.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x DATA_W storage with a synchronous write port and an asynchronous read port.
// Contents are never reset.
module fifo_mem_2p #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Synchronous FIFO: registered occupancy and threshold flags, sticky overflow/underflow,
// and either first-word-fall-through or registered-read output stage.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1,
  parameter int unsigned FWFT     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  input  logic                     clr_err,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     pop_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = cnt_w(DEPTH);

  localparam logic [CNT_W-1:0]  FullCnt = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  AfCnt   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0]  AeCnt   = CNT_W'(AE_LEVEL);
  localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);
  localparam logic [ADDR_W:0]   PtrOne  = (ADDR_W + 1)'(1);

  if (DATA_W < 1) begin : gen_bad_data_w
    $fatal(1, "DATA_W must be at least 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_bad_depth
    $fatal(1, "DEPTH must be a power of two and at least 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : gen_bad_af
    $fatal(1, "AF_LEVEL must lie in 1..DEPTH");
  end
  if (AE_LEVEL > DEPTH - 1) begin : gen_bad_ae
    $fatal(1, "AE_LEVEL must lie in 0..DEPTH-1");
  end

  logic [ADDR_W:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q, empty_q, af_q, ae_q;
  logic               ovf_q, ovf_d, udf_q, udf_d;
  logic               push_acc, pop_acc;
  logic [DATA_W-1:0]  rd_data;

  // Acceptance looks only at the current state: no write-through when full, no bypass when empty.
  assign push_acc = push && !full_q;
  assign pop_acc  = pop && !empty_q;

  always_comb begin
    count_d = count_q;
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  // A new error outranks a coincident clear.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (push && full_q) ovf_d = 1'b1;
    if (pop && empty_q) udf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop_acc)  rd_ptr_q <= rd_ptr_q + PtrOne;
      count_q <= count_d;
      full_q  <= (count_d == FullCnt);
      empty_q <= (count_d == '0);
      af_q    <= (count_d >= AfCnt);
      ae_q    <= (count_d <= AeCnt);
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_acc),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (push_data),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (rd_data)
  );

  if (FWFT != 0) begin : gen_fwft
    assign pop_data  = rd_data;
    assign pop_valid = !empty_q;
  end else begin : gen_reg_read
    logic [DATA_W-1:0] pop_data_q;
    logic              pop_valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        pop_data_q  <= '0;
        pop_valid_q <= 1'b0;
      end else begin
        pop_valid_q <= pop_acc;
        if (pop_acc) pop_data_q <= rd_data;
      end
    end

    assign pop_data  = pop_data_q;
    assign pop_valid = pop_valid_q;
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Drives an FWFT and a registered-read FIFO with identical stimulus and checks both
// against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int DW = 8;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] push_data = '0;

  logic [DW-1:0] pd_a, pd_b;
  logic          pv_a, pv_b, full_a, full_b, empty_a, empty_b;
  logic          af_a, af_b, ae_a, ae_b, ovf_a, ovf_b, udf_a, udf_b;
  logic [3:0]    cnt_a, cnt_b;

  sync_fifo_param #(
    .DATA_W(DW), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)
  ) u_fwft (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
    .clr_err(clr_err), .pop_data(pd_a), .pop_valid(pv_a), .full(full_a),
    .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a), .count(cnt_a),
    .overflow(ovf_a), .underflow(udf_a)
  );

  sync_fifo_param #(
    .DATA_W(DW), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)
  ) u_regrd (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
    .clr_err(clr_err), .pop_data(pd_b), .pop_valid(pv_b), .full(full_b),
    .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b), .count(cnt_b),
    .overflow(ovf_b), .underflow(udf_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model
  logic [DW-1:0] q[$];
  bit            m_ovf = 1'b0;
  bit            m_udf = 1'b0;
  bit            m_pv0 = 1'b0;
  logic [DW-1:0] m_pd0 = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state();
    int n;
    n = q.size();
    check("count_fwft",  32'(cnt_a),   n);
    check("count_reg",   32'(cnt_b),   n);
    check("empty_fwft",  32'(empty_a), (n == 0));
    check("empty_reg",   32'(empty_b), (n == 0));
    check("full_fwft",   32'(full_a),  (n == D));
    check("full_reg",    32'(full_b),  (n == D));
    check("afull_fwft",  32'(af_a),    (n >= AF));
    check("afull_reg",   32'(af_b),    (n >= AF));
    check("aempty_fwft", 32'(ae_a),    (n <= AE));
    check("aempty_reg",  32'(ae_b),    (n <= AE));
    check("ovf_fwft",    32'(ovf_a),   m_ovf);
    check("ovf_reg",     32'(ovf_b),   m_ovf);
    check("udf_fwft",    32'(udf_a),   m_udf);
    check("udf_reg",     32'(udf_b),   m_udf);
    check("valid_fwft",  32'(pv_a),    (n > 0));
    if (n > 0) check("data_fwft", 32'(pd_a), 32'(q[0]));
    check("valid_reg",   32'(pv_b),    m_pv0);
    check("data_reg",    32'(pd_b),    32'(m_pd0));
  endtask

  task automatic step(input bit ps, input logic [DW-1:0] d, input bit pp, input bit ce,
                      input bit r);
    bit pa, po;
    push = ps; push_data = d; pop = pp; clr_err = ce; rst = r;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_pv0 = 1'b0; m_pd0 = '0;
    end else begin
      pa = ps && (q.size() < D);
      po = pp && (q.size() > 0);
      if (ps && q.size() == D) m_ovf = 1'b1;
      else if (ce)             m_ovf = 1'b0;
      if (pp && q.size() == 0) m_udf = 1'b1;
      else if (ce)             m_udf = 1'b0;
      m_pv0 = po;
      if (po) m_pd0 = q.pop_front();
      if (pa) q.push_back(d);
    end
    #1 check_state();
  endtask

  task automatic drain();
    for (int i = 0; i < D + 1; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int pbias, qbias;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Fill 0x10..0x17, then one rejected push at full, then drain in order
    for (int i = 0; i < D; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < D; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // clr_err coinciding with another full push keeps overflow set
    for (int i = 0; i < D; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    drain();
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Pop on empty with a simultaneous push: push wins, pop is an underflow
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Sustained push+pop at count 4 walks the pointers around twice
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h80 + i), 1'b1, 1'b0, 1'b0);
    drain();

    // Registered read: value holds after the pulse
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Reset mid-stream with push asserted; stale words must never reappear
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Randomised traffic with phases biased toward filling or draining
    for (int ph = 0; ph < 8; ph++) begin
      pbias = $urandom_range(20, 90);
      qbias = $urandom_range(20, 90);
      for (int i = 0; i < 100; i++) begin
        step($urandom_range(99) < pbias, 8'($urandom), $urandom_range(99) < qbias,
             $urandom_range(19) == 0, $urandom_range(199) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
